// File: rtl/score_card_controller.sv
// ---------------------------------------------------------------------------
// score_card_controller
//
// Scorecard bookkeeping for a Yacht-style dice game. A commit request is
// checked against the card while IDLE. A legal request latches its category
// and moves to SEL, where calc_sel steers the external combinational score
// calculator to that category. On the following edge the calculator result
// (score_in) is stored, the running sums are updated, and commit_ack pulses.
// Illegal requests pulse commit_err and leave the card untouched.
// clear_game wipes the card and overrides any commit in flight.
//
// Ports
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   commit       one-cycle request to record commit_cat
//   commit_cat   category code 0..11 (0 Aces .. 5 Sixes, 6 Choice, 7 4-Kind,
//                8 Full House, 9 S.Straight, 10 L.Straight, 11 Yacht)
//   preview_cat  category forwarded to the calculator while idle
//   clear_game   synchronous scorecard wipe, highest priority
//   score_in     calculator result for calc_sel, stored unmodified
//   read_cat     lookup index for read_score
//   calc_sel     category select to the score calculator
//   busy         high while a commit is in progress (state SEL)
//   commit_ack   one-cycle pulse when a commit has been recorded
//   commit_err   one-cycle pulse when a commit is rejected
//   used_mask    bit k set once category k has been recorded
//   read_score   stored score of read_cat, 0 if out of range or unused
//   upper_sum    sum of categories 0..5
//   bonus        upper_sum >= 63
//   total        upper_sum + 35*bonus + sum of categories 6..11 (registered)
//   game_over    all twelve categories recorded
// ---------------------------------------------------------------------------
module score_card_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       commit,
   input  logic [3:0] commit_cat,
   input  logic [3:0] preview_cat,
   input  logic       clear_game,
   input  logic [7:0] score_in,
   input  logic [3:0] read_cat,
   output logic [3:0] calc_sel,
   output logic       busy,
   output logic       commit_ack,
   output logic       commit_err,
   output logic [11:0] used_mask,
   output logic [7:0] read_score,
   output logic [6:0] upper_sum,
   output logic       bonus,
   output logic [8:0] total,
   output logic       game_over
);

   localparam int NUM_CATS        = 12;
   localparam int UPPER_CATS      = 6;
   localparam int BONUS_THRESHOLD = 63;
   localparam int BONUS_VALUE     = 35;

   typedef enum logic {
      IDLE = 1'b0,
      SEL  = 1'b1
   } state_t;

   state_t     state;
   logic [3:0] cat_q;                 // category latched for the commit in flight
   logic [7:0] slots [NUM_CATS];      // recorded score per category
   logic [8:0] lower_sum;             // sum of categories 6..11

   logic       commit_reject;
   logic [15:0] used_ext;
   logic [6:0] upper_next;
   logic [8:0] lower_next;
   logic [8:0] total_next;

   // ------------------------------------------------------------------------
   // Combinational outputs derived from registered state
   // ------------------------------------------------------------------------
   assign busy      = (state == SEL);
   assign calc_sel  = (state == SEL) ? cat_q : preview_cat;
   assign bonus     = (upper_sum >= 7'(BONUS_THRESHOLD));
   assign game_over = &used_mask;

   // Codes 12..15 are padded as "already used", so a single lookup rejects
   // both out-of-range and repeated categories.
   assign used_ext      = {4'hF, used_mask};
   assign commit_reject = used_ext[commit_cat] | game_over;

   // NOTE: every always_comb output gets a default before any conditional
   // assignment so no path leaves it unassigned, which would infer a latch.
   always_comb begin
      read_score = 8'd0;
      for (int i = 0; i < NUM_CATS; i++) begin
         if (read_cat == 4'(i) && used_mask[i]) begin
            read_score = slots[i];
         end
      end
   end

   // Sums after recording score_in into cat_q; total is precomputed here so
   // it lands in the register on the same edge that raises commit_ack.
   always_comb begin
      upper_next = upper_sum;
      lower_next = lower_sum;
      if (cat_q < 4'(UPPER_CATS)) begin
         upper_next = 7'({1'b0, upper_sum} + score_in);
      end else begin
         lower_next = lower_sum + {1'b0, score_in};
      end
      total_next = {2'b00, upper_next} + lower_next
                 + ((upper_next >= 7'(BONUS_THRESHOLD)) ? 9'(BONUS_VALUE) : 9'd0);
   end

   // ------------------------------------------------------------------------
   // Controller state, scorecard storage and registered pulses
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cat_q      <= 4'd0;
         used_mask  <= 12'd0;
         upper_sum  <= 7'd0;
         lower_sum  <= 9'd0;
         total      <= 9'd0;
         commit_ack <= 1'b0;
         commit_err <= 1'b0;
         // NOTE: the slot array is small and read_score must never expose a
         // stale score, so it is reset like ordinary flops rather than being
         // left uninitialised as a RAM would be.
         for (int i = 0; i < NUM_CATS; i++) begin
            slots[i] <= 8'd0;
         end
      end else begin
         commit_ack <= 1'b0;
         commit_err <= 1'b0;

         if (clear_game) begin
            // Overrides everything, including a commit waiting in SEL.
            state     <= IDLE;
            cat_q     <= 4'd0;
            used_mask <= 12'd0;
            upper_sum <= 7'd0;
            lower_sum <= 9'd0;
            total     <= 9'd0;
            for (int i = 0; i < NUM_CATS; i++) begin
               slots[i] <= 8'd0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (commit) begin
                     if (commit_reject) begin
                        commit_err <= 1'b1;
                     end else begin
                        cat_q <= commit_cat;
                        state <= SEL;
                     end
                  end
               end

               SEL: begin
                  // Any commit seen here is ignored: no ack, no err.
                  for (int i = 0; i < NUM_CATS; i++) begin
                     if (cat_q == 4'(i)) begin
                        slots[i]     <= score_in;
                        used_mask[i] <= 1'b1;
                     end
                  end
                  upper_sum  <= upper_next;
                  lower_sum  <= lower_next;
                  total      <= total_next;
                  commit_ack <= 1'b1;
                  state      <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/score_card_controller.md
SCORE_CARD_CONTROLLER -- requirements
Module: score_card_controller

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; clock and reset ports are listed first below.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 commit  input  1  one-cycle request to record the category on commit_cat.
REQ-005 commit_cat  input  4  category code for the commit request: 0 Aces .. 5 Sixes, 6 Choice, 7 4-Kind, 8 Full House, 9 S.Straight, 10 L.Straight, 11 Yacht.
REQ-006 preview_cat  input  4  category to preview while idle.
REQ-007 clear_game  input  1  synchronous request to wipe the scorecard.
REQ-008 score_in  input  8  score for calc_sel, from the combinational score calculator.
REQ-009 read_cat  input  4  index for the read_score lookup.
REQ-010 calc_sel  output  4  category select driven to the score calculator.
REQ-011 busy  output  1  high while a commit is in progress.
REQ-012 commit_ack  output  1  one-cycle pulse when a commit has been recorded.
REQ-013 commit_err  output  1  one-cycle pulse when a commit is rejected.
REQ-014 used_mask  output  12  bit k set means category k has been recorded.
REQ-015 read_score  output  8  stored score of read_cat; 0 if read_cat > 11 or the category is unused.
REQ-016 upper_sum  output  7  sum of categories 0..5 (max 105).
REQ-017 bonus  output  1  high when upper_sum >= 63.
REQ-018 total  output  9  upper_sum + 35*bonus + sum of categories 6..11 (max 319).
REQ-019 game_over  output  1  high when used_mask == 12'hFFF.

Function
REQ-020 SHALL implement a state machine with states IDLE and SEL, plus registered outputs commit_ack and commit_err.
REQ-021 In IDLE, calc_sel SHALL equal preview_cat; in SEL, calc_sel SHALL equal the latched category.
REQ-022 Valid commit path: a commit sampled in IDLE at edge N SHALL latch commit_cat and move the machine to SEL.
REQ-023 At edge N+1 the block SHALL write score_in into slot[cat], set used_mask[cat], update upper_sum, lower_sum and total, pulse commit_ack during cycle N+1..N+2, and return to IDLE.
REQ-024 busy SHALL equal (state == SEL).
REQ-025 Reject path: if the commit sampled in IDLE has commit_cat > 11, or used_mask[commit_cat] = 1, or game_over = 1, then:
- commit_err SHALL pulse in the following cycle;
- state and all stored data SHALL remain unchanged.
REQ-026 A commit asserted while in SEL SHALL be ignored, with no ack and no err.
REQ-027 clear_game SHALL take priority over commit in every state, including SEL.
REQ-028 On clear_game, the next edge SHALL clear slots, used_mask, sums, commit_ack and commit_err, and force IDLE; an interrupted commit is discarded.
REQ-029 Arithmetic SHALL be unsigned with no overflow at the stated widths.
REQ-030 total SHALL be a registered value, consistent in the same cycle in which commit_ack is high.
REQ-031 bonus, game_over and read_score SHALL be combinational from registered state.
REQ-032 The block SHALL perform no clamping or checking of score_in; it is stored as-is.

Reset
REQ-033 While rst_n is low, asynchronously:
- state = IDLE;
- all slots, used_mask, upper_sum and total = 0;
- busy, commit_ack, commit_err, bonus and game_over = 0;
- calc_sel follows preview_cat.
REQ-034 Reset asserted in SEL SHALL abort the commit with no slot written.
REQ-035 The first commit SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Full House: commit_cat = 8, score_in = 19 (dice 3,3,3,5,5).
- commit_ack occurs 2 cycles after commit;
- calc_sel = 8 during busy;
- read_score(8) = 19, used_mask = 12'h100, total = 19.
REQ-037 Double commit: commit category 5 with score 18, then commit category 5 again.
- The second commit produces commit_err one cycle later;
- total stays 18, no ack.
REQ-038 Upper bonus: commit categories 0..5 with scores 3, 6, 9, 12, 15, 18.
- upper_sum = 63, bonus = 1, total = 98.
REQ-039 Full game: commit all 12 categories.
- game_over = 1, used_mask = 12'hFFF;
- a 13th commit yields commit_err.
- commit_cat = 12 at any time yields commit_err with no state change.
REQ-040 Interrupted commit:
- clear_game in the SEL cycle -> no ack, all outputs 0 next cycle;
- rst_n low in SEL -> no slot written.
